// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for x^N + x^TAP + 1: locks onto the stream, flags bit errors, saturating count.
// Define PRBS_CHK_INV_EN to add the `inv` port for checking an inverted stream.
module prbs_checker #(
    parameter int N           = 7,
    parameter int TAP         = 6,
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          clr,
`ifdef PRBS_CHK_INV_EN
    input  logic          inv,
`endif
    input  logic          din,
    input  logic          din_valid,
    input  logic          clr_cnt,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_count
);

    localparam int MAX_THRESH = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
    localparam int RW = $clog2(MAX_THRESH + 1);
    localparam int SW = $clog2(N + 1);
    localparam logic [RW-1:0] LOCK_LAST = RW'(LOCK_THRESH - 1);
    localparam logic [RW-1:0] LOSS_LAST = RW'(LOSS_THRESH - 1);
    localparam logic [SW-1:0] SEED_LAST = SW'(N - 1);

    typedef enum logic [1:0] {
        SEED,
        CHECK,
        LOCKED
    } state_t;

    state_t        state, state_next;
    logic [N-1:0]  s, s_next;
    logic [SW-1:0] seed_cnt, seed_next;
    logic [RW-1:0] run_cnt, run_next;
    logic          err_next;
    logic          inc;
    logic          din_eff;
    logic          match;
    logic          s_zero;

`ifdef PRBS_CHK_INV_EN
    assign din_eff = din ^ inv;
`else
    assign din_eff = din;
`endif

    assign match  = (din_eff == (s[N-1] ^ s[TAP-1]));
    assign s_zero = (s == '0);

    // An all-zero history predicts zeros forever, so it is treated as loss of sync, never as errors.
    always_comb begin
        state_next = state;
        s_next     = s;
        seed_next  = seed_cnt;
        run_next   = run_cnt;
        err_next   = 1'b0;
        inc        = 1'b0;
        if (din_valid) begin
            s_next = {s[N-2:0], din_eff};
            case (state)
                SEED: begin
                    if (seed_cnt == SEED_LAST) begin
                        state_next = CHECK;
                        seed_next  = '0;
                        run_next   = '0;
                    end else begin
                        seed_next = seed_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (s_zero) begin
                        state_next = SEED;
                        seed_next  = '0;
                        run_next   = '0;
                    end else if (match) begin
                        if (run_cnt == LOCK_LAST) begin
                            state_next = LOCKED;
                            run_next   = '0;
                        end else begin
                            run_next = run_cnt + 1'b1;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                LOCKED: begin
                    if (s_zero) begin
                        state_next = SEED;
                        seed_next  = '0;
                        run_next   = '0;
                    end else if (!match) begin
                        err_next = 1'b1;
                        inc      = 1'b1;
                        if (run_cnt == LOSS_LAST) begin
                            state_next = SEED;
                            seed_next  = '0;
                            run_next   = '0;
                        end else begin
                            run_next = run_cnt + 1'b1;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                default: begin
                    state_next = SEED;
                    seed_next  = '0;
                    run_next   = '0;
                end
            endcase
        end
    end

    // clr_cnt beats a coincident increment; the count never wraps.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= SEED;
            s         <= '0;
            seed_cnt  <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_next;
            s        <= s_next;
            seed_cnt <= seed_next;
            run_cnt  <= run_next;
            locked   <= (state_next == LOCKED);
            err      <= err_next;
            if (clr_cnt) begin
                err_count <= '0;
            end else if (inc && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: default instance plus a CW=4 instance sharing the same stimulus.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err;
    logic [15:0] err_count;
    logic        locked4, err4;
    logic [3:0]  err_count4;

    logic [6:0]  g;
    int          checks = 0;
    int          errors = 0;
    int          pulses;
    int          lock_hi;
    int          lock_lo;

    prbs_checker dut (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count)
    );

    prbs_checker #(.CW(4)) dut4 (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked4), .err(err4), .err_count(err_count4)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, sample just after the edge and tally err pulses / locked cycles.
    task automatic apply_stimulus(input logic b, input logic v);
        din       = b;
        din_valid = v;
        @(posedge clk);
        #1;
        if (err === 1'b1) pulses++;
        if (locked === 1'b1) lock_hi++;
        else lock_lo++;
    endtask

    // Reference generator x^7+x^6+1, seeded 7'h7F.
    task automatic gen_next(output logic b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    function automatic logic [3:0] peek4(input logic [6:0] st);
        logic [3:0] r;
        logic       nb;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            nb   = st[6] ^ st[5];
            st   = {st[5:0], nb};
            r[i] = nb;
        end
        return r;
    endfunction

    task automatic feed_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            apply_stimulus(b, 1'b1);
        end
    endtask

    task automatic do_reset();
        clr     = 1'b1;
        clr_cnt = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        clr     = 1'b0;
        g       = 7'h7F;
        pulses  = 0;
        lock_hi = 0;
        lock_lo = 0;
    endtask

    initial begin
        logic b;
        int   found;

        // Reset state and first lock on a clean stream
        do_reset();
        check_output("reset_locked", {31'd0, locked}, 32'd0);
        check_output("reset_err", {31'd0, err}, 32'd0);
        check_output("reset_count", {16'd0, err_count}, 32'd0);
        check_output("reset_count4", {28'd0, err_count4}, 32'd0);
        feed_clean(22);
        check_output("locked_before_23", lock_hi, 0);
        feed_clean(1);
        check_output("lock_at_23", {31'd0, locked}, 32'd1);
        lock_lo = 0;
        feed_clean(477);
        check_output("clean_pulses", pulses, 0);
        check_output("clean_count", {16'd0, err_count}, 32'd0);
        check_output("clean_stays_locked", lock_lo, 0);

        // Single flipped bit at 100 -> three mismatches
        do_reset();
        feed_clean(99);
        pulses  = 0;
        lock_lo = 0;
        gen_next(b);
        apply_stimulus(~b, 1'b1);
        feed_clean(100);
        check_output("flip_pulses", pulses, 3);
        check_output("flip_count", {16'd0, err_count}, 32'd3);
        check_output("flip_count4", {28'd0, err_count4}, 32'd3);
        check_output("flip_locked", lock_lo, 0);

        // All-zero stream never locks and never errors
        do_reset();
        for (int i = 0; i < 200; i++) apply_stimulus(1'b0, 1'b1);
        check_output("zero_locked", lock_hi, 0);
        check_output("zero_pulses", pulses, 0);
        check_output("zero_count", {16'd0, err_count}, 32'd0);

        // Constant ones injected just before a run of four zeros: four consecutive mismatches drop lock
        do_reset();
        feed_clean(23);
        check_output("ones_prelock", {31'd0, locked}, 32'd1);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (peek4(g) == 4'b0000) found = 1;
            else feed_clean(1);
        end
        check_output("ones_search_found", found, 1);
        pulses = 0;
        apply_stimulus(1'b1, 1'b1);
        check_output("ones_err1", {31'd0, err}, 32'd1);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        check_output("ones_locked_after3", {31'd0, locked}, 32'd1);
        apply_stimulus(1'b1, 1'b1);
        check_output("ones_err4", {31'd0, err}, 32'd1);
        check_output("ones_locked_after4", {31'd0, locked}, 32'd0);
        check_output("ones_pulses", pulses, 4);
        check_output("ones_count", {16'd0, err_count}, 32'd4);
        lock_hi = 0;
        feed_clean(22);
        check_output("relock_early", lock_hi, 0);
        feed_clean(1);
        check_output("relock_at_23", {31'd0, locked}, 32'd1);
        check_output("relock_count_held", {16'd0, err_count}, 32'd4);

        // 20 flips, 20 bits apart: 60 errors, CW=4 saturates at 15
        do_reset();
        feed_clean(23);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            gen_next(b);
            apply_stimulus(~b, 1'b1);
            feed_clean(19);
        end
        check_output("sat_pulses", pulses, 60);
        check_output("sat_count16", {16'd0, err_count}, 32'd60);
        check_output("sat_count4", {28'd0, err_count4}, 32'd15);
        check_output("sat_locked4", {31'd0, locked4}, 32'd1);
        clr_cnt = 1'b1;
        gen_next(b);
        apply_stimulus(~b, 1'b1);
        clr_cnt = 1'b0;
        check_output("clrcnt_err", {31'd0, err}, 32'd1);
        check_output("clrcnt_err4", {31'd0, err4}, 32'd1);
        check_output("clrcnt_count", {16'd0, err_count}, 32'd0);
        check_output("clrcnt_count4", {28'd0, err_count4}, 32'd0);
        feed_clean(7);
        check_output("clrcnt_after", {16'd0, err_count}, 32'd2);

        // din_valid toggling: lock after 23 valid bits, invalid cycles carry garbage
        do_reset();
        for (int i = 0; i < 22; i++) begin
            gen_next(b);
            apply_stimulus(b, 1'b1);
            apply_stimulus(~b, 1'b0);
        end
        check_output("toggle_early", lock_hi, 0);
        gen_next(b);
        apply_stimulus(b, 1'b1);
        check_output("toggle_lock_45", {31'd0, locked}, 32'd1);
        apply_stimulus(~b, 1'b0);
        check_output("toggle_lock_46", {31'd0, locked}, 32'd1);
        pulses = 0;
        gen_next(b);
        apply_stimulus(~b, 1'b1);
        apply_stimulus(b, 1'b0);
        for (int i = 0; i < 7; i++) begin
            gen_next(b);
            apply_stimulus(b, 1'b1);
            apply_stimulus(~b, 1'b0);
        end
        check_output("toggle_pulses", pulses, 3);
        check_output("toggle_count", {16'd0, err_count}, 32'd3);

        // Reset mid-LOCKED overrides a valid bit
        clr = 1'b1;
        gen_next(b);
        apply_stimulus(b, 1'b1);
        clr = 1'b0;
        check_output("midclr_locked", {31'd0, locked}, 32'd0);
        check_output("midclr_count", {16'd0, err_count}, 32'd0);
        check_output("midclr_count4", {28'd0, err_count4}, 32'd0);
        check_output("midclr_err", {31'd0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
